hazard_sequencer: RTL and testbench

- Pipeline sequencing controller that sits beside ControlUnit in the ID stage.
- Tracks the EXE and MEM stage destination registers in shadow registers.
- Generates the forwarding selects (qaSel, qbSel) and all stall, bubble and flush controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Sequences three conditions: load-use stalls, data-memory wait states and taken-branch/jump redirect flushes.

---
 rtl/hazard_sequencer.sv | 176 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// ID-stage hazard sequencer: forwarding selects plus stall/bubble/flush/freeze control.
// Optional HAZARD_PERF_CNT_EN adds ldStallCnt/flushCnt/memWaitCnt event counters.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int RA_W         = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idValid,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic            useRs1,
  input  logic            useRs2,
  input  logic [RA_W-1:0] idRd,
  input  logic            idWreg,
  input  logic            idM2reg,
  input  logic            redirect,
  input  logic            memBusy,
  output logic [1:0]      qaSel,
  output logic [1:0]      qbSel,
  output logic [RA_W-1:0] erd,
  output logic [RA_W-1:0] mrd,
  output logic            pcStall,
  output logic            ifidStall,
  output logic            idexBubble,
  output logic            ifidFlush,
  output logic            pipeFreeze,
  output logic [1:0]      state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     ldStallCnt,
  output logic [31:0]     flushCnt,
  output logic [31:0]     memWaitCnt
`endif
);

  // Handshake-free control block: every output is a pure function of the
  // registered state, the shadows and this cycle's ID/EXE/MEM inputs.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_fcnt;
  logic            r_e_valid;
  logic            r_e_wreg;
  logic            r_e_m2reg;
  logic [RA_W-1:0] r_e_rd;
  logic            r_m_valid;
  logic            r_m_wreg;
  logic [RA_W-1:0] r_m_rd;

  logic            w_lu;
  logic            w_freeze;
  logic            w_flush;
  logic            w_ldstall;
  logic            w_e_in_valid;
  logic [1:0]      w_next_state;
  logic [1:0]      w_next_fcnt;

  function automatic logic [1:0] fwd_sel(
    input logic            use_rs,
    input logic [RA_W-1:0] rs,
    input logic            e_valid,
    input logic            e_wreg,
    input logic            e_m2reg,
    input logic [RA_W-1:0] e_rd,
    input logic            m_valid,
    input logic            m_wreg,
    input logic [RA_W-1:0] m_rd
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_rs && (rs != '0)) begin
      if (e_valid && e_wreg && !e_m2reg && (e_rd == rs)) begin
        sel = 2'd1;
      end else if (m_valid && m_wreg && (m_rd == rs)) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  assign qaSel = fwd_sel(useRs1, rs1, r_e_valid, r_e_wreg, r_e_m2reg, r_e_rd,
                         r_m_valid, r_m_wreg, r_m_rd);
  assign qbSel = fwd_sel(useRs2, rs2, r_e_valid, r_e_wreg, r_e_m2reg, r_e_rd,
                         r_m_valid, r_m_wreg, r_m_rd);

  assign w_lu = idValid && r_e_valid && r_e_m2reg && (r_e_rd != '0) &&
                ((useRs1 && (rs1 == r_e_rd)) || (useRs2 && (rs2 == r_e_rd)));

  // MEMWAIT and LDSTALL fall through to the RUN evaluation once memBusy drops.
  always_comb begin
    w_freeze     = 1'b0;
    w_flush      = 1'b0;
    w_ldstall    = 1'b0;
    w_next_state = ST_RUN;
    w_next_fcnt  = r_fcnt;
    if (memBusy) begin
      w_freeze     = 1'b1;
      w_next_state = (r_state == ST_FLUSH) ? ST_FLUSH : ST_MEMWAIT;
    end else if (redirect) begin
      w_flush      = 1'b1;
      w_next_fcnt  = FLUSH_LOAD;
      w_next_state = (FLUSH_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
    end else if (r_state == ST_FLUSH) begin
      w_flush      = 1'b1;
      w_next_fcnt  = (r_fcnt == 2'd0) ? 2'd0 : r_fcnt - 2'd1;
      w_next_state = (r_fcnt <= 2'd1) ? ST_RUN : ST_FLUSH;
    end else if (w_lu) begin
      w_ldstall    = 1'b1;
      w_next_state = ST_LDSTALL;
    end
  end

  assign pipeFreeze   = w_freeze;
  assign pcStall      = w_freeze | w_ldstall;
  assign ifidStall    = w_freeze | w_ldstall;
  assign idexBubble   = w_flush | w_ldstall;
  assign ifidFlush    = w_flush;
  assign state        = r_state;
  assign erd          = r_e_rd;
  assign mrd          = r_m_rd;
  assign w_e_in_valid = idValid & ~idexBubble & ~ifidFlush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_fcnt    <= 2'd0;
      r_e_valid <= 1'b0;
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_e_rd    <= '0;
      r_m_valid <= 1'b0;
      r_m_wreg  <= 1'b0;
      r_m_rd    <= '0;
    end else begin
      r_state <= w_next_state;
      r_fcnt  <= w_next_fcnt;
      if (!w_freeze) begin
        r_m_valid <= r_e_valid;
        r_m_wreg  <= r_e_wreg;
        r_m_rd    <= r_e_rd;
        r_e_valid <= w_e_in_valid;
        r_e_wreg  <= w_e_in_valid & idWreg;
        r_e_m2reg <= w_e_in_valid & idM2reg;
        r_e_rd    <= w_e_in_valid ? idRd : '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_ld_cnt;
  logic [31:0] r_fl_cnt;
  logic [31:0] r_mw_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_cnt <= '0;
      r_fl_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      r_ld_cnt <= r_ld_cnt + {31'd0, w_ldstall};
      r_fl_cnt <= r_fl_cnt + {31'd0, w_flush};
      r_mw_cnt <= r_mw_cnt + {31'd0, w_freeze};
    end
  end

  assign ldStallCnt = r_ld_cnt;
  assign flushCnt   = r_fl_cnt;
  assign memWaitCnt = r_mw_cnt;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer (FLUSH_CYCLES=2): stage-queue model checked every cycle
// plus directed literal expectations; counter checks when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_sequencer;

  localparam int FC = 2;

  logic       clk;
  logic       rst;
  logic       idValid;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       useRs1;
  logic       useRs2;
  logic [4:0] idRd;
  logic       idWreg;
  logic       idM2reg;
  logic       redirect;
  logic       memBusy;
  logic [1:0] qaSel;
  logic [1:0] qbSel;
  logic [4:0] erd;
  logic [4:0] mrd;
  logic       pcStall;
  logic       ifidStall;
  logic       idexBubble;
  logic       ifidFlush;
  logic       pipeFreeze;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ldStallCnt;
  logic [31:0] flushCnt;
  logic [31:0] memWaitCnt;
`endif

  hazard_sequencer #(.FLUSH_CYCLES(FC), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .rs1(rs1), .rs2(rs2),
    .useRs1(useRs1), .useRs2(useRs2), .idRd(idRd), .idWreg(idWreg),
    .idM2reg(idM2reg), .redirect(redirect), .memBusy(memBusy),
    .qaSel(qaSel), .qbSel(qbSel), .erd(erd), .mrd(mrd),
    .pcStall(pcStall), .ifidStall(ifidStall), .idexBubble(idexBubble),
    .ifidFlush(ifidFlush), .pipeFreeze(pipeFreeze), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .ldStallCnt(ldStallCnt), .flushCnt(flushCnt), .memWaitCnt(memWaitCnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_rst_req = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions in flight beyond ID: pipe_q[0] is MEM, pipe_q[1] is EXE.
  typedef struct packed {
    bit       v;
    bit       w;
    bit       ld;
    bit [4:0] rd;
  } slot_t;

  slot_t pipe_q[$];
  slot_t m_new;
  int    flush_left;
  int    exp_state;
  bit    model_ok = 1'b0;
  bit    m_lu;
  bit    m_freeze;
  bit    m_flush;
  bit    m_stall;
  int    cnt_ld;
  int    cnt_fl;
  int    cnt_mw;

  function automatic int fwd(input bit use_rs, input logic [4:0] rs);
    if (!use_rs || rs == 5'd0) return 0;
    if (pipe_q[1].v && pipe_q[1].w && !pipe_q[1].ld && pipe_q[1].rd == rs) return 1;
    if (pipe_q[0].v && pipe_q[0].w && pipe_q[0].rd == rs) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pipe_q.delete();
      pipe_q.push_back('0);
      pipe_q.push_back('0);
      flush_left = 0;
      exp_state  = 0;
      cnt_ld     = 0;
      cnt_fl     = 0;
      cnt_mw     = 0;
      model_ok   = 1'b1;
    end else if (model_ok) begin
      m_lu = idValid && pipe_q[1].v && pipe_q[1].ld && pipe_q[1].rd != 5'd0 &&
             ((useRs1 && rs1 == pipe_q[1].rd) || (useRs2 && rs2 == pipe_q[1].rd));
      m_freeze = memBusy;
      m_flush  = !m_freeze && (redirect || flush_left > 0);
      m_stall  = !m_freeze && !m_flush && m_lu;

      chk("m_qaSel", int'(qaSel), fwd(useRs1, rs1));
      chk("m_qbSel", int'(qbSel), fwd(useRs2, rs2));
      chk("m_erd", int'(erd), int'(pipe_q[1].rd));
      chk("m_mrd", int'(mrd), int'(pipe_q[0].rd));
      chk("m_pcStall", int'(pcStall), int'(m_freeze || m_stall));
      chk("m_ifidStall", int'(ifidStall), int'(m_freeze || m_stall));
      chk("m_idexBubble", int'(idexBubble), int'(m_flush || m_stall));
      chk("m_ifidFlush", int'(ifidFlush), int'(m_flush));
      chk("m_pipeFreeze", int'(pipeFreeze), int'(m_freeze));
      chk("m_state", int'(state), exp_state);

      cnt_ld += int'(m_stall);
      cnt_fl += int'(m_flush);
      cnt_mw += int'(m_freeze);

      if (m_freeze) begin
        exp_state = (flush_left > 0) ? 3 : 2;
      end else begin
        if (redirect) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
        if (m_flush) exp_state = (flush_left > 0) ? 3 : 0;
        else if (m_stall) exp_state = 1;
        else exp_state = 0;
        m_new = '0;
        if (idValid && !m_flush && !m_stall) begin
          m_new.v  = 1'b1;
          m_new.w  = idWreg;
          m_new.ld = idM2reg;
          m_new.rd = idRd;
        end
        void'(pipe_q.pop_front());
        pipe_q.push_back(m_new);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks happen after the falling edge.
  task automatic cyc(input bit v, input logic [4:0] a, input logic [4:0] b,
                     input bit ua, input bit ub, input logic [4:0] d,
                     input bit w, input bit ld, input bit rdr, input bit busy);
    @(posedge clk);
    #1;
    rst      = tb_rst_req;
    idValid  = v;
    rs1      = a;
    rs2      = b;
    useRs1   = ua;
    useRs2   = ub;
    idRd     = d;
    idWreg   = w;
    idM2reg  = ld;
    redirect = rdr;
    memBusy  = busy;
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    cyc(1, a, b, 1, 1, d, 1, 0, 0, 0);
  endtask
  task automatic ldi(input logic [4:0] d, input logic [4:0] a);
    cyc(1, a, 0, 1, 0, d, 1, 1, 0, 0);
  endtask
  task automatic add_busy(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    cyc(1, a, b, 1, 1, d, 1, 0, 0, 1);
  endtask
  task automatic redir_nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic busy_nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; idValid = 0; rs1 = 0; rs2 = 0; useRs1 = 0; useRs2 = 0;
    idRd = 0; idWreg = 0; idM2reg = 0; redirect = 0; memBusy = 0;

    tb_rst_req = 1'b1;
    repeat (3) nop();
    tb_rst_req = 1'b0;
    nop();
    chk("rst_state", int'(state), 0);
    chk("rst_erd", int'(erd), 0);
    chk("rst_mrd", int'(mrd), 0);
    chk("rst_stall", int'(pcStall | ifidStall | idexBubble | ifidFlush | pipeFreeze), 0);
    chk("rst_sel", int'({qaSel, qbSel}), 0);

    // EXE then MEM forwarding
    add(5, 1, 2);
    add(6, 5, 5);
    chk("fwd_exe_qa", int'(qaSel), 1);
    chk("fwd_exe_qb", int'(qbSel), 1);
    chk("fwd_exe_erd", int'(erd), 5);
    add(9, 5, 0);
    chk("fwd_mem_qa", int'(qaSel), 2);
    chk("fwd_x0_qb", int'(qbSel), 0);
    chk("fwd_mem_mrd", int'(mrd), 5);
    chk("fwd_nostall", int'(pcStall), 0);
    nop(); nop();

    // load-use
    ldi(7, 1);
    add(8, 7, 0);
    chk("lu_pcStall", int'(pcStall), 1);
    chk("lu_bubble", int'(idexBubble), 1);
    chk("lu_qa_noexe", int'(qaSel), 0);
    add(8, 7, 0);
    chk("lu_state1", int'(state), 1);
    chk("lu_qa_mem", int'(qaSel), 2);
    chk("lu_released", int'(pcStall), 0);
    chk("lu_erd_bubble", int'(erd), 0);
    chk("lu_mrd", int'(mrd), 7);
    nop();
    chk("lu_erd_adv", int'(erd), 8);
    nop(); nop();

    // redirect flush for FC=2 cycles
    cyc(1, 1, 2, 1, 1, 10, 1, 0, 1, 0);
    chk("rd_flush0", int'(ifidFlush), 1);
    chk("rd_bubble0", int'(idexBubble), 1);
    add(11, 1, 2);
    chk("rd_flush1", int'(ifidFlush), 1);
    chk("rd_state3", int'(state), 3);
    add(12, 1, 2);
    chk("rd_done", int'(ifidFlush), 0);
    chk("rd_state0", int'(state), 0);
    chk("rd_erd", int'(erd), 0);
    nop();
    chk("rd_erd_adv", int'(erd), 12);
    nop(); nop();

    // memBusy during a load-use condition
    ldi(13, 1);
    for (int i = 0; i < 4; i++) begin
      add_busy(14, 13, 13);
      chk("mw_freeze", int'(pipeFreeze), 1);
      chk("mw_nobubble", int'(idexBubble), 0);
      chk("mw_erd_hold", int'(erd), 13);
    end
    chk("mw_state", int'(state), 2);
    add(14, 13, 13);
    chk("mw_exit_freeze", int'(pipeFreeze), 0);
    chk("mw_exit_lu", int'(pcStall), 1);
    add(14, 13, 13);
    chk("mw_ldstall", int'(state), 1);
    chk("mw_qb_mem", int'(qbSel), 2);
    chk("mw_mrd", int'(mrd), 13);
    nop();
    chk("mw_erd_adv", int'(erd), 14);
    nop(); nop();

    // load to x0 never stalls or forwards
    ldi(0, 1);
    cyc(1, 0, 2, 1, 1, 15, 1, 0, 0, 0);
    chk("x0_nostall", int'(pcStall), 0);
    chk("x0_qa", int'(qaSel), 0);
    nop(); nop();

    // memBusy inside FLUSH freezes the counter
    redir_nop();
    busy_nop();
    chk("fb_freeze", int'(pipeFreeze), 1);
    chk("fb_noflush", int'(ifidFlush), 0);
    chk("fb_state", int'(state), 3);
    busy_nop();
    nop();
    chk("fb_flush", int'(ifidFlush), 1);
    chk("fb_state2", int'(state), 3);
    nop();
    chk("fb_done", int'(ifidFlush), 0);
    chk("fb_run", int'(state), 0);

    // redirect reload during FLUSH
    redir_nop();
    redir_nop();
    chk("rl_state", int'(state), 3);
    nop();
    chk("rl_flush", int'(ifidFlush), 1);
    nop();
    chk("rl_done", int'(ifidFlush), 0);

    // reset aborts a flush
    redir_nop();
    tb_rst_req = 1'b1;
    nop();
    tb_rst_req = 1'b0;
    nop();
    chk("ra_state", int'(state), 0);
    chk("ra_flush", int'(ifidFlush), 0);

    // one load-use, one redirect, four wait cycles
    ldi(20, 1);
    add(21, 20, 0);
    add(21, 20, 0);
    redir_nop();
    nop();
    nop();
    repeat (4) busy_nop();
    nop();
`ifdef HAZARD_PERF_CNT_EN
    chk("pc_ld", int'(ldStallCnt), 1);
    chk("pc_fl", int'(flushCnt), 2);
    chk("pc_mw", int'(memWaitCnt), 4);
    chk("pc_ld_model", int'(ldStallCnt), cnt_ld);
    chk("pc_fl_model", int'(flushCnt), cnt_fl);
    chk("pc_mw_model", int'(memWaitCnt), cnt_mw);
`endif
    chk("model_ld", cnt_ld, 1);
    chk("model_fl", cnt_fl, 2);
    chk("model_mw", cnt_mw, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
